// File: rtl/fix_framer.sv
// fix_framer: delimits FIX messages, strips the "10=NNN" trailer and
// forwards body bytes to the checksum stage.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   data_i/valid_i      received byte stream (accepted when ready_o)
//   ready_o             low only while waiting for the checksum result
//   data_o/valid_o      body bytes ('8' .. SOH before "10=")
//   start_o             with the first body byte of a message
//   end_o               cycle after the last body byte
//   rx_checksum_o       decoded trailer value, held until next decode
//   calc_checksum_i     checksum from the checksum stage
//   calc_valid_i        pulse qualifying calc_checksum_i
//   done_o              verdict pulse; qualifies match_o / fmt_err_o
//   match_o             calc == rx and trailer well formed
//   fmt_err_o           malformed trailer
module fix_framer #(
   parameter logic [7:0] SOH        = 8'h01,
   parameter logic [7:0] BEGIN_CHAR = 8'h38
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_i,
   input  logic       valid_i,
   output logic       ready_o,
   output logic [7:0] data_o,
   output logic       valid_o,
   output logic       start_o,
   output logic       end_o,
   output logic [7:0] rx_checksum_o,
   input  logic [7:0] calc_checksum_i,
   input  logic       calc_valid_i,
   output logic       done_o,
   output logic       match_o,
   output logic       fmt_err_o
);

   localparam logic [7:0] EQ_CHAR   = 8'h3D;
   localparam logic [7:0] ZERO_CHAR = 8'h30;
   localparam logic [7:0] ONE_CHAR  = 8'h31;
   localparam logic [7:0] NINE_CHAR = 8'h39;

   typedef enum logic [1:0] {
      IDLE,
      BODY,
      TRAIL,
      CMP
   } state_t;

   state_t state, state_nxt;

   // Delay line: s2 oldest, s0 newest.  s2 never needs its
   // field-start bit, since only s1's is consulted by the detector.
   logic [7:0] d0, d1, d2;
   logic       v0, v1, v2;
   logic       f0, f1;

   logic       prev_soh;
   logic       start_arm;
   logic       end_q;
   logic       done_q;
   logic       match_q;
   logic       fmt_q;
   logic       err;
   logic [9:0] acc;
   logic [1:0] cnt;
   logic [7:0] rx_q;

   logic       accept;
   logic       is_digit;
   logic       emit;
   logic       trl_hit;

   assign ready_o  = (state != CMP);
   assign accept   = valid_i && ready_o;
   assign is_digit = (data_i >= ZERO_CHAR) && (data_i <= NINE_CHAR);

   assign valid_o       = emit;
   assign data_o        = emit ? d2 : 8'h00;
   assign start_o       = emit && start_arm;
   assign end_o         = end_q;
   assign done_o        = done_q;
   assign match_o       = match_q;
   assign fmt_err_o     = fmt_q;
   assign rx_checksum_o = rx_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      emit      = 1'b0;
      trl_hit   = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept && data_i == BEGIN_CHAR) begin
               state_nxt = BODY;
            end
         end
         BODY: begin
            if (accept) begin
               emit = v2;
               // "SOH 1 0 =" with the '1' opening a field
               trl_hit = (data_i == EQ_CHAR)
                  && v0 && (d0 == ZERO_CHAR)
                  && v1 && (d1 == ONE_CHAR) && f1;
               if (trl_hit) begin
                  state_nxt = TRAIL;
               end
            end
         end
         TRAIL: begin
            if (accept && data_i == SOH) begin
               state_nxt = CMP;
            end
         end
         CMP: begin
            if (calc_valid_i) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d0        <= 8'h00;
         d1        <= 8'h00;
         d2        <= 8'h00;
         v0        <= 1'b0;
         v1        <= 1'b0;
         v2        <= 1'b0;
         f0        <= 1'b0;
         f1        <= 1'b0;
         prev_soh  <= 1'b0;
         start_arm <= 1'b0;
         end_q     <= 1'b0;
         done_q    <= 1'b0;
         match_q   <= 1'b0;
         fmt_q     <= 1'b0;
         err       <= 1'b0;
         acc       <= 10'd0;
         cnt       <= 2'd0;
         rx_q      <= 8'h00;
      end else begin
         end_q   <= trl_hit;
         done_q  <= 1'b0;
         match_q <= 1'b0;
         fmt_q   <= 1'b0;
         if (accept) begin
            prev_soh <= (data_i == SOH);
         end
         unique case (state)
            IDLE: begin
               if (accept && data_i == BEGIN_CHAR) begin
                  d0        <= data_i;
                  v0        <= 1'b1;
                  f0        <= 1'b0;
                  v1        <= 1'b0;
                  f1        <= 1'b0;
                  v2        <= 1'b0;
                  start_arm <= 1'b1;
               end
            end
            BODY: begin
               if (accept) begin
                  if (emit) begin
                     start_arm <= 1'b0;
                  end
                  if (trl_hit) begin
                     // s2 (the SOH) leaves this cycle; "10" is
                     // trailer, so the line is simply emptied.
                     v0  <= 1'b0;
                     v1  <= 1'b0;
                     v2  <= 1'b0;
                     acc <= 10'd0;
                     cnt <= 2'd0;
                     err <= 1'b0;
                  end else begin
                     d2 <= d1;
                     v2 <= v1;
                     d1 <= d0;
                     v1 <= v0;
                     f1 <= f0;
                     d0 <= data_i;
                     v0 <= 1'b1;
                     f0 <= prev_soh;
                  end
               end
            end
            TRAIL: begin
               if (accept) begin
                  if (data_i == SOH) begin
                     err  <= err || (cnt != 2'd3)
                             || (acc > 10'd255);
                     rx_q <= acc[7:0];
                  end else if (is_digit) begin
                     // count saturates at 3; extra digits are errors
                     if (cnt == 2'd3) begin
                        err <= 1'b1;
                     end else begin
                        acc <= (acc * 10'd10)
                               + {6'd0, data_i[3:0]};
                        cnt <= cnt + 2'd1;
                     end
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            CMP: begin
               if (calc_valid_i) begin
                  done_q  <= 1'b1;
                  match_q <= (calc_checksum_i == rx_q) && !err;
                  fmt_q   <= err;
               end
            end
            default: begin
               err <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fix_framer.sv
// tb_fix_framer: randomized FIX frames checked against a
// message-level reference model.
module tb_fix_framer;

   localparam logic [7:0] SOH = 8'h01;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data_i;
   logic       valid_i;
   logic       ready_o;
   logic [7:0] data_o;
   logic       valid_o;
   logic       start_o;
   logic       end_o;
   logic [7:0] rx_checksum_o;
   logic [7:0] calc_checksum_i;
   logic       calc_valid_i;
   logic       done_o;
   logic       match_o;
   logic       fmt_err_o;

   fix_framer dut (
      .clk             (clk),
      .rst             (rst),
      .data_i          (data_i),
      .valid_i         (valid_i),
      .ready_o         (ready_o),
      .data_o          (data_o),
      .valid_o         (valid_o),
      .start_o         (start_o),
      .end_o           (end_o),
      .rx_checksum_o   (rx_checksum_o),
      .calc_checksum_i (calc_checksum_i),
      .calc_valid_i    (calc_valid_i),
      .done_o          (done_o),
      .match_o         (match_o),
      .fmt_err_o       (fmt_err_o)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   logic [7:0] msg[$];
   logic [7:0] exp_body[$];
   logic [7:0] out_q[$];
   logic [7:0] exp_rx;
   bit         exp_err;
   int         trl_idx;

   int   n_start, n_end, n_done, n_coinc;
   int   start_pos, end_pos;
   logic got_match, got_fmt;

   always @(negedge clk) begin
      if (!rst) begin
         if (start_o) begin
            n_start++;
            start_pos = out_q.size();
         end
         if (valid_o) out_q.push_back(data_o);
         if (end_o) begin
            n_end++;
            end_pos = out_q.size();
         end
         if (done_o) begin
            n_done++;
            got_match = match_o;
            got_fmt   = fmt_err_o;
         end
         if (start_o && (end_o || done_o)) n_coinc++;
      end
   end

   task automatic clear_mon();
      out_q.delete();
      n_start   = 0;
      n_end     = 0;
      n_done    = 0;
      n_coinc   = 0;
      start_pos = -1;
      end_pos   = -1;
      got_match = 1'bx;
      got_fmt   = 1'bx;
   endtask

   function automatic void put(input string s);
      for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
   endfunction

   // Message-level reference: body is everything from the first '8'
   // up to the SOH preceding the first "10=" field; the trailer is
   // parsed as an integer from its first three digits.
   task automatic model();
      int  b;
      int  t;
      int  nd;
      int  val;
      bit  bad;
      exp_body.delete();
      b = 0;
      while (b < msg.size() && msg[b] != 8'h38) b++;
      t = b + 1;
      while (t + 2 < msg.size() &&
             !(msg[t-1] == SOH && msg[t] == 8'h31 &&
               msg[t+1] == 8'h30 && msg[t+2] == 8'h3D)) t++;
      trl_idx = t;
      for (int i = b; i < t; i++) exp_body.push_back(msg[i]);
      nd  = 0;
      val = 0;
      bad = 0;
      for (int k = t + 3; k < msg.size() && msg[k] != SOH; k++) begin
         if (msg[k] >= 8'h30 && msg[k] <= 8'h39) begin
            if (nd < 3) val = val * 10 + int'(msg[k]) - 48;
            nd++;
         end else begin
            bad = 1;
         end
      end
      exp_err = bad || (nd != 3) || (val > 255);
      exp_rx  = 8'(val);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int gap;
      bit took;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      data_i  = b;
      valid_i = 1'b1;
      took    = 1'b0;
      for (int i = 0; i < 20 && !took; i++) begin
         @(negedge clk);
         took = ready_o;
         @(posedge clk);
         #1;
      end
      valid_i = 1'b0;
      data_i  = 8'($urandom);
      if (!took) check("accept_timeout", 0, 1);
   endtask

   task automatic stray_calc();
      calc_checksum_i = 8'($urandom);
      calc_valid_i    = 1'b1;
      @(posedge clk);
      #1;
      calc_valid_i = 1'b0;
   endtask

   // mode 0: fixed calc, 1: calc = model rx, 2: random calc
   task automatic run_frame(input int mode, input logic [7:0] fixed_calc);
      logic [7:0] calc;
      int         sidx;
      int         d;
      bit         exp_match;
      model();
      clear_mon();
      sidx = $urandom_range(0, trl_idx);
      for (int i = 0; i < msg.size(); i++) begin
         if (i == sidx) stray_calc();
         send_byte(msg[i]);
      end
      check("ready_in_cmp", ready_o, 0);
      case (mode)
         0:       calc = fixed_calc;
         1:       calc = exp_rx;
         default: calc = 8'($urandom);
      endcase
      exp_match = (calc == exp_rx) && !exp_err;
      d = $urandom_range(0, 3);
      repeat (d) begin
         @(posedge clk);
         #1;
      end
      calc_checksum_i = calc;
      calc_valid_i    = 1'b1;
      @(posedge clk);
      #1;
      calc_valid_i = 1'b0;
      for (int i = 0; i < 8 && n_done == 0; i++) @(negedge clk);
      check("done_seen", n_done, 1);
      check("ready_after_done", ready_o, 1);
      repeat (3) @(posedge clk);
      #1;
      check("done_count", n_done, 1);
      check("end_count", n_end, 1);
      check("start_count", n_start, 1);
      check("start_pos", start_pos, 0);
      check("end_pos", end_pos, exp_body.size());
      check("no_coincide", n_coinc, 0);
      check("body_len", out_q.size(), exp_body.size());
      for (int i = 0; i < exp_body.size(); i++) begin
         if (i < out_q.size())
            check($sformatf("body_byte_%0d", i), out_q[i], exp_body[i]);
      end
      check("rx_checksum", rx_checksum_o, exp_rx);
      check("match", got_match, exp_match);
      check("fmt_err", got_fmt, exp_err);
   endtask

   task automatic gen_random();
      int v;
      msg.delete();
      repeat ($urandom_range(0, 4)) begin
         do v = $urandom_range(0, 255); while (v == 8'h38);
         msg.push_back(8'(v));
      end
      put("8=FIX.4.4");
      msg.push_back(SOH);
      repeat ($urandom_range(1, 4)) begin
         case ($urandom_range(0, 3))
            0:       put("100");
            1:       put("110");
            2:       put($sformatf("%0d", $urandom_range(11, 999)));
            default: put("1");
         endcase
         put("=");
         repeat ($urandom_range(1, 4))
            msg.push_back(8'($urandom_range(33, 126)));
         msg.push_back(SOH);
      end
      put("10=");
      case ($urandom_range(0, 6))
         0, 1, 2: put($sformatf("%03d", $urandom_range(0, 255)));
         3:       put($sformatf("%02d", $urandom_range(0, 99)));
         4:       put($sformatf("%0d", $urandom_range(256, 999)));
         5: begin
            put($sformatf("%0d", $urandom_range(0, 9)));
            msg.push_back(8'($urandom_range(65, 90)));
            put($sformatf("%0d", $urandom_range(0, 9)));
         end
         default: put($sformatf("%04d", $urandom_range(0, 255)));
      endcase
      msg.push_back(SOH);
   endtask

   task automatic check_cleared(input string pfx);
      check({pfx, "_valid_o"}, valid_o, 0);
      check({pfx, "_start_o"}, start_o, 0);
      check({pfx, "_end_o"}, end_o, 0);
      check({pfx, "_done_o"}, done_o, 0);
      check({pfx, "_match_o"}, match_o, 0);
      check({pfx, "_fmt_err_o"}, fmt_err_o, 0);
      check({pfx, "_rx_checksum_o"}, rx_checksum_o, 0);
      check({pfx, "_data_o"}, data_o, 0);
      check({pfx, "_ready_o"}, ready_o, 1);
   endtask

   task automatic basic_msg();
      msg.delete();
      put("8=A");
      msg.push_back(SOH);
      put("10=123");
      msg.push_back(SOH);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst             = 1'b1;
      data_i          = 8'h00;
      valid_i         = 1'b0;
      calc_checksum_i = 8'h00;
      calc_valid_i    = 1'b0;
      clear_mon();
      #12;
      check_cleared("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;

      basic_msg();
      run_frame(0, 8'h7B);
      check("t1_rx_const", rx_checksum_o, 8'h7B);

      basic_msg();
      run_frame(0, 8'h7C);

      msg.delete();
      put("8=A");
      msg.push_back(SOH);
      put("100=5");
      msg.push_back(SOH);
      put("10=007");
      msg.push_back(SOH);
      run_frame(1, 8'h00);
      check("t3_rx_const", rx_checksum_o, 8'h07);

      msg.delete();
      put("8=A");
      msg.push_back(SOH);
      put("10=12");
      msg.push_back(SOH);
      run_frame(1, 8'h00);

      msg.delete();
      put("8=A");
      msg.push_back(SOH);
      put("10=300");
      msg.push_back(SOH);
      run_frame(1, 8'h00);

      msg.delete();
      put("8=A");
      msg.push_back(SOH);
      put("10=1a3");
      msg.push_back(SOH);
      run_frame(1, 8'h00);

      basic_msg();
      for (int i = 0; i < 5; i++) send_byte(msg[i]);
      clear_mon();
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_cleared("midreset");
      @(posedge clk);
      #3;
      rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("midreset_no_end", n_end, 0);
      check("midreset_no_done", n_done, 0);

      msg.delete();
      repeat (3) msg.push_back(8'h55);
      msg.push_back(SOH);
      msg.push_back(8'h3D);
      put("8=A");
      msg.push_back(SOH);
      put("10=123");
      msg.push_back(SOH);
      run_frame(0, 8'h7B);

      for (int f = 0; f < 40; f++) begin
         gen_random();
         run_frame($urandom_range(1, 2), 8'h00);
      end

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule

// File: doc/fix_framer.md
Name: fix_framer

Overview:
- Upstream framing stage for the message checksum block.
- Takes the raw received FIX byte stream and delimits each message from the leading "8" through the SOH (0x01) that precedes the trailer tag "10=".
- Forwards those body bytes with start/end markers to the checksum stage.
- Decodes the three ASCII digits of the received "10=NNN" trailer to binary, then compares them against the checksum stage's result and reports match or error per message.

Parameters:
- SOH, 8'h01, field delimiter byte.
- BEGIN_CHAR, 8'h38, ASCII '8'; first byte of a message.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- data_i  input  8  received byte.
- valid_i  input  1  data_i valid this cycle; byte accepted when valid_i && ready_o.
- ready_o  output  1  block can accept a byte.
- data_o  output  8  body byte to checksum stage.
- valid_o  output  1  data_o valid.
- start_o  output  1  one-cycle pulse coincident with the first valid_o of a message.
- end_o  output  1  one-cycle pulse on the cycle after the last body byte.
- rx_checksum_o  output  8  decoded trailer value; held until next decode.
- calc_checksum_i  input  8  checksum computed by the checksum stage.
- calc_valid_i  input  1  calc_checksum_i valid (pulse).
- done_o  output  1  one-cycle pulse: verdict available.
- match_o  output  1  qualified by done_o: calc == rx and no format error.
- fmt_err_o  output  1  qualified by done_o: malformed trailer.

Behaviour:
- Reset (async, any state): state=IDLE; delay line empty; all flags cleared. Outputs: ready_o=1, valid_o=0, start_o=0, end_o=0, done_o=0, match_o=0, fmt_err_o=0, rx_checksum_o=0, data_o=0.
- Reset mid-message discards all partial state; no end_o or done_o is issued.
- States: IDLE, BODY, TRAIL, CMP.
- IDLE
  - Accepted bytes other than BEGIN_CHAR are dropped.
  - On BEGIN_CHAR: push it to the delay line, go to BODY, and arm start_o.
- Delay line: 3-entry shift register (s2 oldest, s0 newest). Each entry holds a byte, a valid bit and a field-start bit (field-start = previous accepted byte was SOH).
  - Each accepted byte in BODY shifts the line.
  - If the outgoing s2 is valid, it drives data_o/valid_o on that same cycle.
  - start_o accompanies the first such emission of the message.
  - Body latency: 3 accepted bytes.
- Trailer detect in BODY. Condition: incoming byte = '=', s0='0', s1='1', s1.field-start=1.
  - s2 (the SOH) is emitted normally that cycle.
  - s1/s0 are invalidated and not emitted; '=' is not pushed.
  - end_o pulses next cycle; go to TRAIL.
  - Tags such as "100=" or "110=" do not match the condition and pass through as body bytes.
- TRAIL
  - Accepts digits '0'..'9' into a 10-bit accumulator: acc = acc*10 + (byte-0x30), with a digit count.
  - On SOH: error if count != 3, if any non-digit byte was received before SOH, or if acc > 255.
  - Then load rx_checksum_o = acc[7:0] and go to CMP.
  - Bytes after a third digit that are not SOH set the error flag; they do not overflow the count (saturate at 3).
- CMP
  - ready_o=0.
  - Waits for calc_valid_i. Next cycle: done_o=1, match_o = (calc == rx_checksum_o) && !err, fmt_err_o = err.
  - Then return to IDLE with ready_o=1.
  - A calc_valid_i pulse arriving outside CMP is ignored.
  - calc_valid_i on the cycle CMP is entered counts.
- valid_i=0 cycles stall every state with no state change.
- end_o and done_o never coincide with start_o; a new message cannot begin until done_o has issued.

Test Plan:
1. Basic frame: stream "8=A",SOH,"10=123",SOH; calc_checksum_i=8'h7B.
   -> data_o = 38,3D,41,01, with start_o on 38; end_o after 01; rx_checksum_o=8'h7B; done_o=1, match_o=1, fmt_err_o=0.
2. Mismatch: same stream; calc_checksum_i=8'h7C.
   -> done_o=1, match_o=0, fmt_err_o=0.
3. Lookalike tag: "8=A",SOH,"100=5",SOH,"10=007",SOH.
   -> "100=5",SOH appear on data_o; rx_checksum_o=8'h07.
4. Malformed trailers, each -> fmt_err_o=1, match_o=0:
   - "10=12",SOH (two digits).
   - "10=300",SOH (value > 255).
   - "10=1a3",SOH (non-digit).
5. Async reset: assert rst mid-BODY, between valid bytes.
   -> outputs cleared immediately with no end_o/done_o; next clean frame passes as in test 1.
6. Noise and stalls: garbage bytes before '8' in IDLE, plus random valid_i gaps throughout.
   -> garbage dropped; results identical to test 1; ready_o=0 only while in CMP.
